led_trail_pwm: RTL
==================

# led_trail_pwm

Downstream stage of the 10-LED chaser. Takes the chaser's one-hot `led` vector and drives the physical LED pins. Each LED gets a 4-bit brightness level that jumps to full when its input bit is set and then decays stepwise after the bit clears. The result is a fading comet trail behind the running light, rendered with a shared PWM counter.

## Interface
- `W_LED`, 10: number of LED channels.
- `LEVEL_W`, 4: brightness level width; `LEVEL_MAX` = 2^LEVEL_W−1 = 15.
- `PWM_DIV`, 4: clk_50M cycles per PWM counter step (≥1).
- `DECAY_DIV`, 4096: clk_50M cycles per decay tick (≥2).

Ports:
- `clk_50M` in 1: system clock, 50 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `led_in` in W_LED: pattern from the chaser. Same clock domain, no synchroniser.
- `led_out` out W_LED: registered PWM drive to the LED pins. Bit i lit when 1.

## Operation
- Reset: all `level[i]`=0, `pwm_cnt`=0, `pwm_pre`=0, `decay_cnt`=0, `led_out`=0. Reset asserted mid-operation clears everything immediately, with no trail.
- Prescaler `pwm_pre` counts 0..PWM_DIV−1 and wraps. `pwm_cnt` (LEVEL_W bits) increments when `pwm_pre`==PWM_DIV−1 and wraps 15→0. PWM period = 16·PWM_DIV cycles.
- `decay_cnt` counts 0..DECAY_DIV−1 and wraps. `decay_tick`=1 for exactly one cycle when `decay_cnt`==DECAY_DIV−1.
- Per channel i, priority order:
  - `led_in[i]`=1 → `level[i]` ← 15. Load wins over a coincident decay tick.
  - else if `decay_tick` and `level[i]`≠0 → `level[i]` ← `level[i]`−1.
  - else hold. Saturates at 0, never underflows.
- Duty value `d[i]` = `level[i]` (linear) or gamma(`level[i]`) (see Configuration).
- `led_out[i]` ← (`d[i]` > `pwm_cnt`), registered. Duty = `d`/16. Level 15 gives 15/16 on, level 0 is fully off.
- Channels are independent. Multiple `led_in` bits may be set at once; non-one-hot input is legal.

## Timing
- `led_in[i]` sampled at edge N → `level[i]`=15 after edge N. `led_out[i]` reflects the new level after edge N+1. Latency is 2 cycles, plus PWM phase.
- Full fade 15→0 takes 15 decay ticks. Worst case ≈ 15·DECAY_DIV cycles (61440 ≈ 1.23 ms at default).
- Decay ticks are free-running and not aligned to `led_in` edges. The first decrement after release occurs 1..DECAY_DIV cycles later.
- `pwm_cnt` and `decay_cnt` free-run continuously after reset and never stall.

## Configuration
- `LED_TRAIL_GAMMA_EN` defined: `d[i]` = GAMMA[`level[i]`], using the 16-entry LUT 0,0,0,1,1,1,2,2,3,4,5,6,8,10,12,15 for perceptually even fade.
- Not defined: `d[i]` = `level[i]` (linear). The LUT is not synthesised.
- Level storage, decay and latency are identical in both builds.

## Structure
- Package `led_trail_pkg`:
  - `LEVEL_W` and `LEVEL_MAX` constants.
  - `level_t` typedef.
  - Gamma LUT constant and the `gamma_f(level_t)` function, guarded by the macro.
- Top `led_trail_pwm` owns the prescaler, `pwm_cnt`, `decay_cnt` and `decay_tick`, and generates W_LED instances of the sub-module.
- Sub-module `led_trail_cell` contains one channel: level register, load/decay logic, duty map and output compare flop. Inputs are `in_bit`, `decay_tick` and `pwm_cnt`; output is `out_bit`.

## Test plan
Bench parameters: PWM_DIV=1, DECAY_DIV=8.
- Reset: assert `reset_n`=0 at any time → `led_out`=0 and all levels=0 in the same cycle. After release, `pwm_cnt` steps 0,1,…,15,0 each cycle.
- Steady on: `led_in`=10'b00000_00001 held → `level[0]`=15 after 1 cycle. `led_out[0]` is high 15 of every 16 cycles and low when `pwm_cnt`=15. Other bits stay 0.
- Decay (linear build): set `led_in[3]`=1, then clear it → `level[3]` goes 15,14,…,0, one step per `decay_tick` (every 8 cycles). It stays at 0. The duty of `led_out[3]` tracks level/16.
- Load vs decay collision: `led_in[5]` rises on the same cycle as `decay_tick` while `level[5]`=7 → `level[5]`=15, not 6.
- Chaser sweep: drive one-hot 0→9 with a new bit every 16 cycles → the trailing channels hold descending levels. Expected values are `level[i]` = 15 minus the number of decay ticks since release of channel i.
- Gamma build (`LED_TRAIL_GAMMA_EN`): `level`=8 → `led_out` high 3 of 16 cycles. `level`=2 → never high. `level`=15 → high 15 of 16.

Source files
------------

// File: rtl/led_trail_pkg.sv
// Shared level type, limits and optional gamma duty map for the LED trail stage.
// LED_TRAIL_GAMMA_EN adds the gamma LUT and gamma_f; otherwise duty is linear.
package led_trail_pkg;

   localparam int LEVEL_W   = 4;
   localparam int LEVEL_MAX = (1 << LEVEL_W) - 1;

   typedef logic [LEVEL_W-1:0] level_t;

`ifdef LED_TRAIL_GAMMA_EN
   // Entry n sits at bits [4n+3:4n]; table reads 0,0,0,1,1,1,2,2,3,4,5,6,8,10,12,15.
   localparam logic [16*LEVEL_W-1:0] GAMMA_LUT = {
      4'd15, 4'd12, 4'd10, 4'd8, 4'd6, 4'd5, 4'd4, 4'd3,
      4'd2,  4'd2,  4'd1,  4'd1, 4'd1, 4'd0, 4'd0, 4'd0
   };

   function automatic level_t gamma_f(input level_t lvl);
      return GAMMA_LUT[{lvl, 2'b00} +: LEVEL_W];
   endfunction
`endif

endpackage

// File: rtl/led_trail_cell.sv
// One LED channel: level register with load/decay, duty map and registered PWM compare.
// Load-to-level 1 cycle, level-to-out_bit 1 cycle; duty map set by LED_TRAIL_GAMMA_EN.
module led_trail_cell
   import led_trail_pkg::*;
(
   input  logic   clk_50M,
   input  logic   reset_n,
   input  logic   in_bit,
   input  logic   decay_tick,
   input  level_t pwm_cnt,
   output logic   out_bit
);

   level_t r_level;
   level_t w_duty;
   logic   r_out;

   // A set input always wins over a coincident decay tick; decay stops at zero.
   always_ff @(posedge clk_50M or negedge reset_n) begin
      if (!reset_n) begin
         r_level <= '0;
      end else if (in_bit) begin
         r_level <= level_t'(LEVEL_MAX);
      end else if (decay_tick && (r_level != '0)) begin
         r_level <= r_level - level_t'(1);
      end
   end

`ifdef LED_TRAIL_GAMMA_EN
   assign w_duty = gamma_f(r_level);
`else
   assign w_duty = r_level;
`endif

   always_ff @(posedge clk_50M or negedge reset_n) begin
      if (!reset_n) begin
         r_out <= 1'b0;
      end else begin
         r_out <= (w_duty > pwm_cnt);
      end
   end

   assign out_bit = r_out;

endmodule

// File: rtl/led_trail_pwm.sv
// Fading comet-trail LED driver: shared PWM/decay timebase plus W_LED channel cells.
// led_in to led_out latency 2 cycles plus PWM phase; gamma duty via LED_TRAIL_GAMMA_EN.
module led_trail_pwm
   import led_trail_pkg::*;
#(
   parameter int W_LED     = 10,
   parameter int PWM_DIV   = 4,
   parameter int DECAY_DIV = 4096
) (
   input  logic             clk_50M,
   input  logic             reset_n,
   input  logic [W_LED-1:0] led_in,
   output logic [W_LED-1:0] led_out
);

   // PWM_DIV of 1 would give a zero-width prescaler, so keep at least one bit.
   localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
   localparam int DEC_W = $clog2(DECAY_DIV);

   logic [PRE_W-1:0] r_pwm_pre;
   level_t           r_pwm_cnt;
   logic [DEC_W-1:0] r_decay_cnt;
   logic             w_pre_wrap;
   logic             w_decay_tick;
   logic [W_LED-1:0] w_out;

   assign w_pre_wrap   = (r_pwm_pre == PRE_W'(PWM_DIV - 1));
   assign w_decay_tick = (r_decay_cnt == DEC_W'(DECAY_DIV - 1));

   always_ff @(posedge clk_50M or negedge reset_n) begin
      if (!reset_n) begin
         r_pwm_pre <= '0;
         r_pwm_cnt <= '0;
      end else begin
         r_pwm_pre <= w_pre_wrap ? '0 : r_pwm_pre + PRE_W'(1);
         if (w_pre_wrap) begin
            r_pwm_cnt <= r_pwm_cnt + level_t'(1);
         end
      end
   end

   // Free-running; decay ticks are deliberately not aligned to led_in edges.
   always_ff @(posedge clk_50M or negedge reset_n) begin
      if (!reset_n) begin
         r_decay_cnt <= '0;
      end else begin
         r_decay_cnt <= w_decay_tick ? '0 : r_decay_cnt + DEC_W'(1);
      end
   end

   for (genvar g = 0; g < W_LED; g++) begin : g_cell
      led_trail_cell u_cell (
         .clk_50M    (clk_50M),
         .reset_n    (reset_n),
         .in_bit     (led_in[g]),
         .decay_tick (w_decay_tick),
         .pwm_cnt    (r_pwm_cnt),
         .out_bit    (w_out[g])
      );
   end

   assign led_out = w_out;

endmodule
